// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the fetch front end.
//   XLEN             : architectural register / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_NOP        : canonical NOP encoding (addi x0, x0, 0)
//   fetch_state_t    : fetch FSM states
package cpu_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

   // ST_IDLE    : no request outstanding
   // ST_WAIT    : request outstanding, response will be queued
   // ST_DISCARD : request outstanding, response will be dropped
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- single-clock FIFO of DEPTH entries, WIDTH bits each.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wdata  : write an entry (ignored when full or flushing)
//   pop          : drop the head entry (ignored when empty or flushing)
//   flush        : empty the FIFO at the next edge; dominates push and pop
//   rdata        : head entry, zero when empty
//   empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap at DEPTH naturally.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (count != FULL_COUNT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: reads are masked to zero while empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch unit with a small prefetch queue.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   redirect, redirect_pc : taken branch/jump; flush queue and refetch
//   ready_id              : IF/ID accepts the head entry this cycle
//   mem_req, mem_addr     : instruction memory request (registered)
//   mem_ack, mem_rdata    : memory response
//   valid_if, instrucao_if, pc_if, pc_plus4_if : head of the queue
//   fsm_state             : current fetch FSM state (debug)
//
// Handshakes: a memory transfer completes on a rising edge where
// mem_req=1 and mem_ack=1; mem_req/mem_addr hold steady until then, and an
// ack in the very first cycle of a request is legal. A queue entry is
// consumed on a rising edge where valid_if=1 and ready_id=1.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            ready_id,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            valid_if,
   output logic [XLEN-1:0] instrucao_if,
   output logic [XLEN-1:0] pc_if,
   output logic [XLEN-1:0] pc_plus4_if,
   output fetch_state_t    fsm_state
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW+1:0]   DEPTH_W = (AW+2)'(DEPTH);

   fetch_state_t      state;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   redirect_target;
   logic [AW:0]       count;
   logic              empty;
   logic              push;
   logic              pop;
   logic [2*XLEN-1:0] head;
   logic [AW+1:0]     entries_next;
   logic              can_issue;

   assign redirect_target = redirect_pc & ~(XLEN'(3));

   // Only a response to a live (non-discarded) request is queued; the
   // fifo itself drops the push when redirect flushes it.
   assign push = (state == ST_WAIT) && mem_ack;
   assign pop  = valid_if && ready_id;

   // Queue entries after this edge. A new request may only be launched if
   // its eventual response is guaranteed a slot, so the outstanding request
   // is counted as occupied space.
   assign entries_next = (AW+2)'(count) + (AW+2)'(push) - (AW+2)'(pop);
   assign can_issue    = !redirect && (entries_next < DEPTH_W);

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata ({mem_addr, mem_rdata}),
      .rdata (head),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         if (redirect)  fetch_pc <= redirect_target;
         else if (push) fetch_pc <= fetch_pc + XLEN'(4);

         case (state)
            ST_IDLE: begin
               if (can_issue) begin
                  state    <= ST_WAIT;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  if (can_issue) begin
                     // back-to-back: next sequential word, request stays up
                     mem_addr <= fetch_pc + XLEN'(4);
                  end else begin
                     state   <= ST_IDLE;
                     mem_req <= 1'b0;
                  end
               end else if (redirect) begin
                  // request cannot be withdrawn; let it finish and drop it
                  state <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (mem_ack) begin
                  state   <= ST_IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign valid_if               = !empty;
   assign {pc_if, instrucao_if}  = head;
   assign pc_plus4_if            = pc_if + XLEN'(4);
   assign fsm_state              = state;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 redirect  in  1  taken branch/jump from EX; flush and refetch.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to zero.
REQ-007 ready_id  in  1  IF/ID can accept; driven as ~stall from hazard logic.
REQ-008 mem_req  out  1  instruction memory request.
REQ-009 mem_addr  out  32  word-aligned request address.
REQ-010 mem_ack  in  1  request complete; mem_rdata valid this cycle.
REQ-011 mem_rdata  in  32  fetched instruction word.
REQ-012 valid_if  out  1  head entry present.
REQ-013 instrucao_if  out  32  head instruction.
REQ-014 pc_if  out  32  head instruction address.
REQ-015 pc_plus4_if  out  32  pc_if + 4, modulo 2^32.

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (outstanding request whose response is dropped).
REQ-017 IDLE->WAIT when not redirect and occupancy < DEPTH; mem_req=1 and mem_addr=fetch_pc in that cycle.
REQ-018 mem_req and mem_addr stay stable from assertion until the cycle mem_ack=1; at most one request outstanding.
REQ-019 Handshake completes in the cycle mem_req=1 and mem_ack=1; zero-wait ack in the issue cycle is legal.
REQ-020 WAIT with mem_ack and no redirect: push {fetch_pc, mem_rdata}; fetch_pc += 4; return to IDLE, or reissue next cycle if space remains.
REQ-021 Occupancy counts queued entries plus the outstanding request; no issue at occupancy == DEPTH, so push never overflows.
REQ-022 Pop when valid_if && ready_id; push and pop in the same cycle leave the count unchanged.
REQ-023 Latency: mem_ack at edge N gives valid_if=1 with that entry at edge N+1 when the queue was empty; no combinational bypass.
REQ-024 valid_if, instrucao_if and pc_if come straight from the head entry; when empty they are zero.
REQ-025 redirect: queue emptied at the next edge; fetch_pc <= {redirect_pc[31:2],2'b00}; a same-cycle push or pop is ignored.
REQ-026 redirect in WAIT without mem_ack: go to DISCARD; mem_req stays held until ack; the response is dropped; then IDLE and fetch from the new pc.
REQ-027 redirect in the cycle mem_ack=1: response dropped; IDLE; new pc used.
REQ-028 redirect in DISCARD: only fetch_pc is updated; the latest redirect wins.
REQ-029 pc arithmetic wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-030 On reset: state=IDLE, fetch_pc=RESET_PC, queue empty, mem_req=0, mem_addr=0, valid_if=0, instrucao_if=0, pc_if=0.
REQ-031 Reset during WAIT or DISCARD abandons the request; mem_req drops asynchronously, and memory treats a dropped request as cancelled.
REQ-032 First request is issued in the first cycle after reset deasserts.

Structure
REQ-033 Package cpu_pkg holds RESET_PC default, fetch state enum, INSTR_NOP = 32'h0000_0013, and XLEN = 32.
REQ-034 One sub-module, fetch_fifo: synchronous DEPTH x 64-bit FIFO with push, pop, flush, empty, count, and pointers wrapping at DEPTH.

Verification
REQ-035 Streaming: mem_ack one cycle after each req with words 32'h00500093.. and ready_id=1 → valid_if high from cycle 3, pc_if = 0,4,8,… with no gaps after fill.
REQ-036 Back-pressure: ready_id=0 for 10 cycles, DEPTH=4 → exactly 4 handshakes, mem_req low afterwards, head holds pc 0; on release 4 pops in order.
REQ-037 Redirect mid-request: redirect_pc=32'h0000_0103 while in WAIT, ack 3 cycles later with 32'hDEADBEEF → word never appears; next mem_addr = 32'h100; queue empty in between.
REQ-038 Simultaneous: redirect with mem_ack and a pop in the same cycle → valid_if=0 next cycle, next request at the redirect address.
REQ-039 Wrap: redirect to 32'hFFFF_FFF8 → pc_if FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_if of FFFF_FFFC = 0.
REQ-040 Reset in WAIT: assert reset between clock edges → mem_req and valid_if fall at once; after release mem_addr = RESET_PC.
